gp_reservation_station: RTL and testbench

Reservation station for general-purpose integer instructions. It sits between the dispatch stage and one execution unit, directly downstream of the general-purpose register file. Dispatch hands it an opcode and two operands: each is either a ready 32-bit value read from the register file, or the RS ID of the entry that will produce it. The station captures missing operands by snooping the result bus, which also drives the register file write port, and issues the oldest fully ready entry to the execution unit through a valid/ready handshake.

---
 rtl/gp_rs_if.sv | 42 ++++
 rtl/gp_reservation_station.sv | 147 ++++++++++++++
 tb/tb_gp_reservation_station.sv | 135 +++++++++++++
 3 files changed

// File: rtl/gp_rs_if.sv
// Dispatch, result-bus and issue signals of the general-purpose reservation station.
// The station uses the slave modport; dispatch, the result bus and the execution unit form the master side.
interface gp_rs_if #(
  parameter int RS_ID_WIDTH  = 5,
  parameter int OPCODE_WIDTH = 8
);
  logic                    dispatch_valid;
  logic                    dispatch_ready;
  logic [RS_ID_WIDTH-1:0]  dispatch_rs_id;
  logic [OPCODE_WIDTH-1:0] dispatch_opcode;
  logic                    dispatch_a_valid;
  logic                    dispatch_b_valid;
  logic [31:0]             dispatch_a_value;
  logic [31:0]             dispatch_b_value;
  logic [RS_ID_WIDTH-1:0]  dispatch_a_rs_id;
  logic [RS_ID_WIDTH-1:0]  dispatch_b_rs_id;

  logic                    result_valid;
  logic [31:0]             result_value;
  logic [RS_ID_WIDTH-1:0]  result_rs_id;

  logic                    issue_valid;
  logic                    issue_ready;
  logic [OPCODE_WIDTH-1:0] issue_opcode;
  logic [31:0]             issue_a;
  logic [31:0]             issue_b;
  logic [RS_ID_WIDTH-1:0]  issue_rs_id;

  modport master (
    output dispatch_valid, dispatch_opcode, dispatch_a_valid, dispatch_b_valid,
           dispatch_a_value, dispatch_b_value, dispatch_a_rs_id, dispatch_b_rs_id,
           result_valid, result_value, result_rs_id, issue_ready,
    input  dispatch_ready, dispatch_rs_id, issue_valid, issue_opcode, issue_a, issue_b, issue_rs_id
  );

  modport slave (
    input  dispatch_valid, dispatch_opcode, dispatch_a_valid, dispatch_b_valid,
           dispatch_a_value, dispatch_b_value, dispatch_a_rs_id, dispatch_b_rs_id,
           result_valid, result_value, result_rs_id, issue_ready,
    output dispatch_ready, dispatch_rs_id, issue_valid, issue_opcode, issue_a, issue_b, issue_rs_id
  );
endinterface

// File: rtl/gp_reservation_station.sv
// Reservation station: allocates dispatched instructions, captures missing operands from
// the result bus, and issues the oldest fully-ready entry to one execution unit.
module gp_reservation_station #(
  parameter int ENTRIES      = 4,
  parameter int RS_ID_WIDTH  = 5,
  parameter int BASE_ID      = 0,
  parameter int OPCODE_WIDTH = 8
) (
  input logic    clk,
  input logic    rst,
  gp_rs_if.slave bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int AGE_W = $clog2(ENTRIES) + 1;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  logic [ENTRIES-1:0]      busy_q, busy_d;
  logic [ENTRIES-1:0]      a_vld_q, a_vld_d, b_vld_q, b_vld_d;
  logic [OPCODE_WIDTH-1:0] op_q [ENTRIES];
  logic [OPCODE_WIDTH-1:0] op_d [ENTRIES];
  logic [31:0]             a_val_q [ENTRIES];
  logic [31:0]             a_val_d [ENTRIES];
  logic [31:0]             b_val_q [ENTRIES];
  logic [31:0]             b_val_d [ENTRIES];
  logic [RS_ID_WIDTH-1:0]  a_tag_q [ENTRIES];
  logic [RS_ID_WIDTH-1:0]  a_tag_d [ENTRIES];
  logic [RS_ID_WIDTH-1:0]  b_tag_q [ENTRIES];
  logic [RS_ID_WIDTH-1:0]  b_tag_d [ENTRIES];
  logic [AGE_W-1:0]        age_q [ENTRIES];
  logic [AGE_W-1:0]        age_d [ENTRIES];

  logic             alloc_ok, sel_ok, accept, fire, a_byp, b_byp;
  logic [IDX_W-1:0] alloc_idx, sel_idx;
  logic [AGE_W-1:0] sel_age;
  logic [ENTRIES-1:0] rdy;

  // Lowest free index wins; descending scan leaves the lowest one last.
  always_comb begin
    alloc_ok  = 1'b0;
    alloc_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        alloc_ok  = 1'b1;
        alloc_idx = IDX_W'(i);
      end
    end
  end

  assign rdy = busy_q & a_vld_q & b_vld_q;

  // Strict '>' keeps the lowest index on equal ages.
  always_comb begin
    sel_ok  = 1'b0;
    sel_idx = '0;
    sel_age = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (rdy[i] && (!sel_ok || age_q[i] > sel_age)) begin
        sel_ok  = 1'b1;
        sel_idx = IDX_W'(i);
        sel_age = age_q[i];
      end
    end
  end

  assign bus.dispatch_ready = alloc_ok;
  assign bus.dispatch_rs_id = RS_ID_WIDTH'(BASE_ID) + RS_ID_WIDTH'(alloc_idx);
  assign bus.issue_valid    = sel_ok;
  assign bus.issue_opcode   = sel_ok ? op_q[sel_idx]    : '0;
  assign bus.issue_a        = sel_ok ? a_val_q[sel_idx] : '0;
  assign bus.issue_b        = sel_ok ? b_val_q[sel_idx] : '0;
  assign bus.issue_rs_id    = sel_ok ? RS_ID_WIDTH'(BASE_ID) + RS_ID_WIDTH'(sel_idx) : '0;

  assign accept = bus.dispatch_valid && alloc_ok;
  assign fire   = sel_ok && bus.issue_ready;
  assign a_byp  = !bus.dispatch_a_valid && bus.result_valid && (bus.dispatch_a_rs_id == bus.result_rs_id);
  assign b_byp  = !bus.dispatch_b_valid && bus.result_valid && (bus.dispatch_b_rs_id == bus.result_rs_id);

  always_comb begin
    busy_d  = busy_q;
    a_vld_d = a_vld_q;
    b_vld_d = b_vld_q;
    op_d    = op_q;
    a_val_d = a_val_q;
    b_val_d = b_val_q;
    a_tag_d = a_tag_q;
    b_tag_d = b_tag_q;
    age_d   = age_q;
    for (int i = 0; i < ENTRIES; i++) begin
      if (busy_q[i] && bus.result_valid) begin
        if (!a_vld_q[i] && a_tag_q[i] == bus.result_rs_id) begin
          a_vld_d[i] = 1'b1;
          a_val_d[i] = bus.result_value;
        end
        if (!b_vld_q[i] && b_tag_q[i] == bus.result_rs_id) begin
          b_vld_d[i] = 1'b1;
          b_val_d[i] = bus.result_value;
        end
      end
      if (accept && busy_q[i] && age_q[i] != AGE_MAX) begin
        age_d[i] = age_q[i] + 1'b1;
      end
    end
    if (fire) begin
      busy_d[sel_idx] = 1'b0;
    end
    // The allocated index is never busy, so it cannot collide with the issuing entry.
    if (accept) begin
      busy_d[alloc_idx]  = 1'b1;
      op_d[alloc_idx]    = bus.dispatch_opcode;
      a_vld_d[alloc_idx] = bus.dispatch_a_valid | a_byp;
      b_vld_d[alloc_idx] = bus.dispatch_b_valid | b_byp;
      a_val_d[alloc_idx] = a_byp ? bus.result_value : bus.dispatch_a_value;
      b_val_d[alloc_idx] = b_byp ? bus.result_value : bus.dispatch_b_value;
      a_tag_d[alloc_idx] = bus.dispatch_a_rs_id;
      b_tag_d[alloc_idx] = bus.dispatch_b_rs_id;
      age_d[alloc_idx]   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy_q  <= '0;
      a_vld_q <= '0;
      b_vld_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        op_q[i]    <= '0;
        a_val_q[i] <= '0;
        b_val_q[i] <= '0;
        a_tag_q[i] <= '0;
        b_tag_q[i] <= '0;
        age_q[i]   <= '0;
      end
    end else begin
      busy_q  <= busy_d;
      a_vld_q <= a_vld_d;
      b_vld_q <= b_vld_d;
      for (int i = 0; i < ENTRIES; i++) begin
        op_q[i]    <= op_d[i];
        a_val_q[i] <= a_val_d[i];
        b_val_q[i] <= b_val_d[i];
        a_tag_q[i] <= a_tag_d[i];
        b_tag_q[i] <= b_tag_d[i];
        age_q[i]   <= age_d[i];
      end
    end
  end
endmodule

// File: tb/tb_gp_reservation_station.sv
// Directed bench for gp_reservation_station (ENTRIES=4, BASE_ID=0): a vector table for
// reset/dispatch/wakeup/bypass plus hand sequences for full station, ordering and backpressure.
module tb_gp_reservation_station;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gp_rs_if #(.RS_ID_WIDTH(5), .OPCODE_WIDTH(8)) bus ();

  gp_reservation_station #(
    .ENTRIES(4), .RS_ID_WIDTH(5), .BASE_ID(0), .OPCODE_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    logic        rst_n;
    logic        dv;
    logic [7:0]  op;
    logic        av;
    logic [31:0] aval;
    logic [4:0]  atag;
    logic        bv;
    logic [31:0] bval;
    logic [4:0]  btag;
    logic        rv;
    logic [31:0] rval;
    logic [4:0]  rtag;
    logic        ir;
    logic        e_dr;
    logic [4:0]  e_did;
    logic        e_iv;
    logic [7:0]  e_iop;
    logic [31:0] e_ia;
    logic [31:0] e_ib;
    logic [4:0]  e_irs;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic vec_t mk(
    logic [31:0] rst_n, dv, op, av, aval, atag, bv, bval, btag, rv, rval, rtag, ir,
    logic [31:0] dr, did, iv, iop, ia, ib, irs);
    vec_t t;
    t.rst_n = rst_n[0]; t.dv = dv[0]; t.op = op[7:0];
    t.av = av[0]; t.aval = aval; t.atag = atag[4:0];
    t.bv = bv[0]; t.bval = bval; t.btag = btag[4:0];
    t.rv = rv[0]; t.rval = rval; t.rtag = rtag[4:0];
    t.ir = ir[0];
    t.e_dr = dr[0]; t.e_did = did[4:0]; t.e_iv = iv[0]; t.e_iop = iop[7:0];
    t.e_ia = ia; t.e_ib = ib; t.e_irs = irs[4:0];
    return t;
  endfunction

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step(input vec_t t, input string nm);
    rst                  = t.rst_n;
    bus.dispatch_valid   = t.dv;
    bus.dispatch_opcode  = t.op;
    bus.dispatch_a_valid = t.av;
    bus.dispatch_a_value = t.aval;
    bus.dispatch_a_rs_id = t.atag;
    bus.dispatch_b_valid = t.bv;
    bus.dispatch_b_value = t.bval;
    bus.dispatch_b_rs_id = t.btag;
    bus.result_valid     = t.rv;
    bus.result_value     = t.rval;
    bus.result_rs_id     = t.rtag;
    bus.issue_ready      = t.ir;
    @(posedge clk);
    #1;
    cmp({nm, ".dispatch_ready"}, 32'(bus.dispatch_ready), 32'(t.e_dr));
    cmp({nm, ".dispatch_rs_id"}, 32'(bus.dispatch_rs_id), 32'(t.e_did));
    cmp({nm, ".issue_valid"},    32'(bus.issue_valid),    32'(t.e_iv));
    cmp({nm, ".issue_opcode"},   32'(bus.issue_opcode),   32'(t.e_iop));
    cmp({nm, ".issue_a"},        bus.issue_a,             t.e_ia);
    cmp({nm, ".issue_b"},        bus.issue_b,             t.e_ib);
    cmp({nm, ".issue_rs_id"},    32'(bus.issue_rs_id),    32'(t.e_irs));
  endtask

  vec_t vecs [13];

  initial begin
    //             rstn dv op     av aval        atag bv bval   btag rv rval          rtag ir  dr did iv iop    ia            ib     irs
    vecs[0]  = mk(0, 1, 'h12,  1, 5,          0,  1, 7,     0,  0, 0,            0,  1,  1, 0,  0, 0,     0,            0,     0);
    vecs[1]  = mk(0, 1, 'h12,  1, 5,          0,  1, 7,     0,  0, 0,            0,  1,  1, 0,  0, 0,     0,            0,     0);
    vecs[2]  = mk(1, 1, 'h12,  1, 5,          0,  1, 7,     0,  0, 0,            0,  0,  1, 1,  1, 'h12,  5,            7,     0);
    vecs[3]  = mk(1, 0, 0,     0, 0,          0,  0, 0,     0,  0, 0,            0,  1,  1, 0,  0, 0,     0,            0,     0);
    vecs[4]  = mk(1, 1, 'h21,  0, 0,          9,  1, 3,     0,  0, 0,            0,  1,  1, 1,  0, 0,     0,            0,     0);
    vecs[5]  = mk(1, 0, 0,     0, 0,          0,  0, 0,     0,  1, 'hDEADBEEF,   9,  0,  1, 1,  1, 'h21,  'hDEADBEEF,   3,     0);
    vecs[6]  = mk(1, 0, 0,     0, 0,          0,  0, 0,     0,  0, 0,            0,  1,  1, 0,  0, 0,     0,            0,     0);
    vecs[7]  = mk(1, 1, 'h33,  0, 0,          9,  1, 'h11,  0,  1, 'h55,         9,  1,  1, 1,  1, 'h33,  'h55,         'h11,  0);
    vecs[8]  = mk(1, 0, 0,     0, 0,          0,  0, 0,     0,  0, 0,            0,  1,  1, 0,  0, 0,     0,            0,     0);
    vecs[9]  = mk(1, 1, 'h44,  1, 'h44,       9,  0, 0,    10,  1, 'h99,         9,  1,  1, 1,  0, 0,     0,            0,     0);
    vecs[10] = mk(1, 0, 0,     0, 0,          0,  0, 0,     0,  1, 'h77,         9,  1,  1, 1,  0, 0,     0,            0,     0);
    vecs[11] = mk(1, 0, 0,     0, 0,          0,  0, 0,     0,  1, 'hAB,        10,  1,  1, 1,  1, 'h44,  'h44,         'hAB,  0);
    vecs[12] = mk(1, 0, 0,     0, 0,          0,  0, 0,     0,  0, 0,            0,  1,  1, 0,  0, 0,     0,            0,     0);

    for (int i = 0; i < 13; i++) step(vecs[i], $sformatf("vec%0d", i));

    // Fill all four entries; entries 0 and 2 wait on the same tag so one broadcast wakes both.
    step(mk(1, 1, 'h40, 0, 0, 16, 1, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0), "fill0");
    step(mk(1, 1, 'h41, 0, 0, 17, 1, 1, 0, 0, 0, 0, 0,  1, 2, 0, 0, 0, 0, 0), "fill1");
    step(mk(1, 1, 'h42, 0, 0, 16, 1, 2, 0, 0, 0, 0, 0,  1, 3, 0, 0, 0, 0, 0), "fill2");
    step(mk(1, 1, 'h43, 0, 0, 19, 1, 3, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0), "fill3");
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h1000, 16, 0,  0, 0, 1, 'h40, 'h1000, 0, 0), "wake02");
    for (int k = 0; k < 5; k++)
      step(mk(1, 1, 'h5A, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0,  0, 0, 1, 'h40, 'h1000, 0, 0), $sformatf("hold%0d", k));
    // Dispatch offered in the cycle entry 0 issues: refused, then accepted into entry 0.
    step(mk(1, 1, 'h55, 1, 'h66, 0, 1, 'h77, 0, 0, 0, 0, 1,  1, 0, 1, 'h42, 'h1000, 2, 2), "issue_e0");
    step(mk(1, 1, 'h55, 1, 'h66, 0, 1, 'h77, 0, 0, 0, 0, 1,  1, 2, 1, 'h55, 'h66, 'h77, 0), "issue_e2");
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0), "issue_new");
    // Older entry 3 beats a younger ready entry at index 0.
    step(mk(1, 1, 'h60, 1, 1, 0, 1, 2, 0, 1, 'h3333, 19, 0,  1, 2, 1, 'h43, 'h3333, 3, 3), "age_vs_idx");
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 2, 1, 'h60, 1, 2, 0), "issue_e3");
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  1, 0, 0, 0, 0, 0, 0), "issue_e0b");
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'h1717, 17, 1,  1, 0, 1, 'h41, 'h1717, 1, 1), "wake_e1");
    // Reset with a ready entry present, plus same-cycle dispatch, snoop and issue.
    step(mk(0, 1, 'h70, 1, 1, 0, 1, 1, 0, 1, 5, 3, 1,  1, 0, 0, 0, 0, 0, 0), "rst_busy");
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0), "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
